// File: rtl/uart_ctrl_decoder.sv
// UART control decoder: receives 8N1 frames (A5 CMD D0 D1 D2 CHK) from a host
// and commits validated commands into the DDS generator's control registers.
module uart_ctrl_decoder #(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned TIMEOUT_CYC = 500_000,
  parameter logic [19:0] FREQ_RST    = 20'd1074,
  parameter logic [6:0]  PWM_RST     = 7'd64
) (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic        uart_rxd,
  output logic        enable,
  output logic [1:0]  wave_word,
  output logic [19:0] freq_word,
  output logic [6:0]  pwm_word,
  output logic        cfg_update,
  output logic        frame_err
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
  localparam int unsigned CntW       = $clog2(ClksPerBit + 1);
  localparam int unsigned GapW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] HalfM1 = CntW'(ClksPerBit / 2 - 1);
  localparam logic [CntW-1:0] FullM1 = CntW'(ClksPerBit - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [2:0] {PsHunt, PsCmd, PsD0, PsD1, PsD2, PsChk} ps_state_e;

  logic rxd_meta, rxd_sync, rxd_prev;

  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid, rx_ferr;

  ps_state_e       ps_q, ps_d;
  logic [7:0]      cmd_q, cmd_d, d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            enable_q, enable_d;
  logic [1:0]      wave_q, wave_d;
  logic [19:0]     freq_q, freq_d;
  logic [6:0]      pwm_q, pwm_d;
  logic            cfg_update_q, cfg_update_d;
  logic            frame_err_q, frame_err_d;
  logic            cmd_valid;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RxIdle;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
    end
  end

  // Receiver next state: mid-bit sampling, LSB first, strobes on the stop bit.
  always_comb begin
    rx_state_d = rx_state_q;
    bit_cnt_d  = bit_cnt_q + CntW'(1);
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    rx_ferr    = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        bit_cnt_d = '0;
        if (rxd_prev && !rxd_sync) rx_state_d = RxStart;
      end
      RxStart: begin
        if (bit_cnt_q == HalfM1) begin
          bit_cnt_d  = '0;
          bit_idx_d  = '0;
          // A line already back high is a glitch, not a start bit.
          rx_state_d = rxd_sync ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (bit_cnt_q == FullM1) begin
          bit_cnt_d = '0;
          shift_d   = {rxd_sync, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (bit_cnt_q == FullM1) begin
          bit_cnt_d  = '0;
          rx_state_d = RxIdle;
          if (rxd_sync) byte_valid = 1'b1;
          else          rx_ferr    = 1'b1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // Parser, gap timer and committed control registers.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      ps_q         <= PsHunt;
      cmd_q        <= '0;
      d0_q         <= '0;
      d1_q         <= '0;
      d2_q         <= '0;
      gap_q        <= '0;
      enable_q     <= 1'b0;
      wave_q       <= 2'b00;
      freq_q       <= FREQ_RST;
      pwm_q        <= PWM_RST;
      cfg_update_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      ps_q         <= ps_d;
      cmd_q        <= cmd_d;
      d0_q         <= d0_d;
      d1_q         <= d1_d;
      d2_q         <= d2_d;
      gap_q        <= gap_d;
      enable_q     <= enable_d;
      wave_q       <= wave_d;
      freq_q       <= freq_d;
      pwm_q        <= pwm_d;
      cfg_update_q <= cfg_update_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign cmd_valid = (cmd_q >= 8'h01) && (cmd_q <= 8'h05);

  // Parser next state; framing error outranks everything, commit only on a good CHK.
  always_comb begin
    ps_d         = ps_q;
    cmd_d        = cmd_q;
    d0_d         = d0_q;
    d1_d         = d1_q;
    d2_d         = d2_q;
    gap_d        = (ps_q == PsHunt) ? '0 : gap_q + GapW'(1);
    enable_d     = enable_q;
    wave_d       = wave_q;
    freq_d       = freq_q;
    pwm_d        = pwm_q;
    cfg_update_d = 1'b0;
    frame_err_d  = 1'b0;
    if (rx_ferr) begin
      frame_err_d = 1'b1;
      ps_d        = PsHunt;
      gap_d       = '0;
    end else if (byte_valid) begin
      gap_d = '0;
      unique case (ps_q)
        PsHunt: if (shift_q == 8'hA5) ps_d = PsCmd;
        PsCmd: begin cmd_d = shift_q; ps_d = PsD0; end
        PsD0:  begin d0_d  = shift_q; ps_d = PsD1; end
        PsD1:  begin d1_d  = shift_q; ps_d = PsD2; end
        PsD2:  begin d2_d  = shift_q; ps_d = PsChk; end
        PsChk: begin
          ps_d = PsHunt;
          if (cmd_valid && (shift_q == (cmd_q ^ d0_q ^ d1_q ^ d2_q))) begin
            cfg_update_d = 1'b1;
            case (cmd_q)
              8'h01: wave_d = d0_q[1:0];
              8'h02: freq_d = {d2_q[3:0], d1_q, d0_q};
              8'h03: pwm_d  = d0_q[6:0];
              8'h04: enable_d = d0_q[0];
              8'h05: begin
                enable_d = d0_q[7];
                wave_d   = d0_q[6:5];
                pwm_d    = d1_q[6:0];
                freq_d   = {4'h0, d2_q, 8'h00};
              end
              default: ;
            endcase
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: ps_d = PsHunt;
      endcase
    end else if ((ps_q != PsHunt) && (gap_q == GapW'(TIMEOUT_CYC))) begin
      frame_err_d = 1'b1;
      ps_d        = PsHunt;
      gap_d       = '0;
    end
  end

  assign enable     = enable_q;
  assign wave_word  = wave_q;
  assign freq_word  = freq_q;
  assign pwm_word   = pwm_q;
  assign cfg_update = cfg_update_q;
  assign frame_err  = frame_err_q;

endmodule
